// File: rtl/tcdm_resp_pkg.sv
// Shared types and constants for the TCDM bank responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tcdm_resp_pkg;

  // Response payload widths; the responder's DATA_WIDTH/ID_WIDTH default to these.
  localparam int unsigned RESP_DATA_W = 32;
  localparam int unsigned RESP_ID_W   = 1;

  // Response opcodes carried on r_opc.
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // One queued response.
  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    logic                   opc;
    logic [RESP_ID_W-1:0]   id;
  } tcdm_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through (first-word bypass when empty).
// Latency: 1 cycle push-to-pop, 0 cycles in fall-through mode when empty.
// Backpressure: full_o/empty_o; pushes at full and pops at empty are ignored.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] usage_o,
  input  dtype             data_i,
  input  logic             push_i,
  output dtype             data_o,
  input  logic             pop_i
);

  dtype             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_pass_thru;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Empty FIFO in fall-through mode presents the incoming word directly.
  assign w_bypass    = FALL_THROUGH && (r_cnt == '0) && push_i;
  assign full_o      = (r_cnt == CNT_W'(DEPTH));
  assign empty_o     = (r_cnt == '0) && !w_bypass;
  assign usage_o     = r_cnt;
  assign data_o      = w_bypass ? data_i : r_mem[r_rd_ptr];
  assign w_push      = push_i && !full_o;
  assign w_pop       = pop_i && !empty_o;
  // A bypassed word consumed in the same cycle never touches storage.
  assign w_pass_thru = w_bypass && w_pop;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (!w_pass_thru) begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push && !w_pass_thru && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Target-side TCDM bank responder: decode, SRAM access, in-order response queue.
// Latency: response visible the cycle after grant when the response FIFO is empty.
// Backpressure: gnt is withheld while queued + in-flight responses would exceed RESP_DEPTH.
module tcdm_bank_responder
  import tcdm_resp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = RESP_DATA_W,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned           ID_WIDTH   = RESP_ID_W,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
  parameter int unsigned           RESP_DEPTH = 2,
  localparam int unsigned          IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tcdm_req,
  output logic                  tcdm_gnt,
  input  logic [ADDR_WIDTH-1:0] tcdm_add,
  input  logic                  tcdm_wen,
  input  logic [DATA_WIDTH-1:0] tcdm_data,
  input  logic [BE_WIDTH-1:0]   tcdm_be,
  input  logic [ID_WIDTH-1:0]   tcdm_id,
  output logic                  tcdm_r_valid,
  input  logic                  tcdm_r_ready,
  output logic [DATA_WIDTH-1:0] tcdm_r_data,
  output logic                  tcdm_r_opc,
  output logic [ID_WIDTH-1:0]   tcdm_r_id,
  output logic                  sram_req,
  output logic                  sram_we,
  output logic [IDX_W-1:0]      sram_addr,
  output logic [BE_WIDTH-1:0]   sram_be,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  // The response struct width is fixed by the package; DATA_WIDTH/ID_WIDTH must match it.
  localparam int unsigned OFF_LSB   = $clog2(BE_WIDTH);
  localparam int unsigned MEM_BYTES = MEM_WORDS * BE_WIDTH;
  localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_credit;
  logic                  w_acc;

  logic                  r_inf_vld;
  logic                  r_inf_rd;
  logic                  r_inf_opc;
  logic [ID_WIDTH-1:0]   r_inf_id;

  tcdm_resp_t            w_push_dat;
  tcdm_resp_t            w_pop_dat;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_usage;

  // Address decode; low byte-lane bits are ignored.
  assign w_off      = tcdm_add - BASE_ADDR;
  assign w_in_range = (w_off < ADDR_WIDTH'(MEM_BYTES));
  assign w_idx      = w_off[OFF_LSB +: IDX_W];

  // Credit: every grant reserves a FIFO slot; uses registered state only, never r_ready.
  assign w_credit = (int'(w_usage) + int'(r_inf_vld)) < int'(RESP_DEPTH);
  assign tcdm_gnt = tcdm_req & w_credit & ~rst_i;
  assign w_acc    = tcdm_gnt;

  // SRAM port is driven only for accepted in-range requests, otherwise idles at zero.
  assign sram_req   = w_acc & w_in_range;
  assign sram_we    = sram_req & ~tcdm_wen;
  assign sram_addr  = sram_req ? w_idx : '0;
  assign sram_be    = sram_req ? (tcdm_wen ? {BE_WIDTH{1'b1}} : tcdm_be) : '0;
  assign sram_wdata = sram_we ? tcdm_data : '0;

  // Hold response metadata for one cycle while the SRAM read completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inf_vld <= 1'b0;
      r_inf_rd  <= 1'b0;
      r_inf_opc <= RESP_OK;
      r_inf_id  <= '0;
    end else begin
      r_inf_vld <= w_acc;
      if (w_acc) begin
        r_inf_rd  <= tcdm_wen;
        r_inf_opc <= w_in_range ? RESP_OK : RESP_ERR;
        r_inf_id  <= tcdm_id;
      end
    end
  end

  // Build the queued response; writes and errors return zero data.
  always_comb begin
    w_push_dat      = '0;
    w_push_dat.data = (r_inf_rd && (r_inf_opc == RESP_OK)) ? sram_rdata : '0;
    w_push_dat.opc  = r_inf_opc;
    w_push_dat.id   = r_inf_id;
  end

  // Credit makes full-at-push impossible; the full guard only keeps state sane.
  assign w_push = r_inf_vld & ~w_fifo_full;
  assign w_pop  = tcdm_r_valid & tcdm_r_ready;

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DEPTH        (RESP_DEPTH),
    .dtype        (tcdm_resp_t)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .usage_o (w_usage),
    .data_i  (w_push_dat),
    .push_i  (w_push),
    .data_o  (w_pop_dat),
    .pop_i   (w_pop)
  );

  // Response channel; payload reads as zero whenever nothing is offered.
  assign tcdm_r_valid = ~w_fifo_empty;
  assign tcdm_r_data  = tcdm_r_valid ? w_pop_dat.data : '0;
  assign tcdm_r_opc   = tcdm_r_valid ? w_pop_dat.opc  : RESP_OK;
  assign tcdm_r_id    = tcdm_r_valid ? w_pop_dat.id   : '0;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Randomised scoreboard bench for tcdm_bank_responder with a word-array SRAM model.
// Latency: checks T+1 response latency whenever r_ready has been held high.
// Backpressure: drives fixed and random r_ready, checks grant credit and response hold.
module tb_tcdm_bank_responder;

  localparam int unsigned MW   = 1024;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tcdm_req, tcdm_gnt, tcdm_wen;
  logic [31:0] tcdm_add, tcdm_data;
  logic [3:0]  tcdm_be;
  logic        tcdm_id;
  logic        tcdm_r_valid, tcdm_r_ready, tcdm_r_opc, tcdm_r_id;
  logic [31:0] tcdm_r_data;
  logic        sram_req, sram_we;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  tcdm_bank_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(1),
    .MEM_WORDS(MW), .BASE_ADDR(BASE), .RESP_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_data(tcdm_data), .tcdm_be(tcdm_be), .tcdm_id(tcdm_id),
    .tcdm_r_valid(tcdm_r_valid), .tcdm_r_ready(tcdm_r_ready), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_opc(tcdm_r_opc), .tcdm_r_id(tcdm_r_id),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_rdy = 0;
  bit lat_mode = 0;

  always @(posedge clk_i) cyc++;

  // Bank macro model: byte-enabled writes, one-cycle read latency.
  logic [31:0] sram_mem [MW];
  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Random response backpressure, applied after the main process's drive point.
  always @(posedge clk_i) begin
    #2;
    if (rand_rdy) tcdm_r_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-addressed memory image plus expected-response queue.
  typedef struct {
    logic [31:0] data;
    logic        opc;
    logic        id;
    int          gcyc;
    bit          chk_lat;
  } exp_t;

  logic [31:0] ref_mem [MW];
  exp_t        sb[$];

  function automatic exp_t model(input logic [31:0] a, input logic wen, input logic [31:0] d,
                                 input logic [3:0] be, input logic id);
    exp_t        e;
    logic [31:0] off;
    int          w;
    off       = a - BASE;
    e.id      = id;
    e.gcyc    = cyc;
    e.chk_lat = lat_mode;
    e.opc     = 1'b0;
    e.data    = 32'h0;
    if (off >= MW * 4) begin
      e.opc = 1'b1;
    end else begin
      w = int'(off / 4);
      if (wen) e.data = ref_mem[w];
      else
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    end
    return e;
  endfunction

  // Monitor: pops on every handshake, checks payload, latency and hold-while-stalled.
  logic        hold_prev = 0;
  logic [31:0] hold_data;
  logic        hold_opc, hold_id;
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", tcdm_r_valid, 1);
        check("hold_data", tcdm_r_data, hold_data);
        check("hold_opc_id", {tcdm_r_opc, tcdm_r_id}, {hold_opc, hold_id});
      end
      if (tcdm_r_valid && tcdm_r_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got data %h opc %0d with no request outstanding",
                   tcdm_r_data, tcdm_r_opc);
        end else begin
          e = sb.pop_front();
          check("resp_data", tcdm_r_data, e.data);
          check("resp_opc", tcdm_r_opc, e.opc);
          check("resp_id", tcdm_r_id, e.id);
          if (e.chk_lat) check("resp_latency", cyc, e.gcyc + 1);
        end
      end
      hold_prev = tcdm_r_valid && !tcdm_r_ready;
      hold_data = tcdm_r_data;
      hold_opc  = tcdm_r_opc;
      hold_id   = tcdm_r_id;
    end
  end

  // Present one request, wait (bounded) for its grant, check SRAM-side decode.
  task automatic issue(input logic [31:0] a, input logic wen, input logic [31:0] d,
                       input logic [3:0] be, input logic id);
    int          waitc = 0;
    bit          got   = 0;
    logic [31:0] off;
    tcdm_req = 1; tcdm_add = a; tcdm_wen = wen; tcdm_data = d; tcdm_be = be; tcdm_id = id;
    while (!got && waitc < 200) begin
      @(negedge clk_i);
      if (tcdm_gnt) got = 1;
      else waitc++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant in %0d cycles, required one", waitc);
    end else begin
      sb.push_back(model(a, wen, d, be, id));
      off = a - BASE;
      if (off < MW * 4) begin
        check("sram_req", sram_req, 1);
        check("sram_we", sram_we, !wen);
        check("sram_addr", sram_addr, off >> 2);
        check("sram_be", sram_be, wen ? 4'hF : be);
        if (!wen) check("sram_wdata", sram_wdata, d);
      end else begin
        check("oob_sram_req", sram_req, 0);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    tcdm_req = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < MW; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    rst_i = 1; tcdm_req = 1; tcdm_add = BASE; tcdm_wen = 1; tcdm_data = '0;
    tcdm_be = '0; tcdm_id = 0; tcdm_r_ready = 0;

    // Reset state, with a request pending to show grant is held off.
    #1;
    check("rst_gnt", tcdm_gnt, 0);
    check("rst_r_valid", tcdm_r_valid, 0);
    check("rst_r_data", tcdm_r_data, 0);
    check("rst_r_opc_id", {tcdm_r_opc, tcdm_r_id}, 0);
    check("rst_sram_ctl", {sram_req, sram_we, sram_be}, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    repeat (3) @(posedge clk_i);
    #3 rst_i = 0; tcdm_req = 0;
    @(posedge clk_i); #1;

    // Full write, readback; partial write, readback.
    tcdm_r_ready = 1; lat_mode = 1;
    issue(BASE + 32'h10, 0, 32'hDEADBEEF, 4'hF, 1);
    issue(BASE + 32'h10, 1, 32'h0, 4'h0, 1);
    issue(BASE + 32'h10, 0, 32'h0000AB00, 4'b0010, 0);
    issue(BASE + 32'h10, 1, 32'h0, 4'h0, 0);
    idle();
    drain();

    // Backpressure: two grants then stall; grant reopens the cycle after the first pop.
    lat_mode = 0; tcdm_r_ready = 0;
    tcdm_req = 1; tcdm_add = BASE + 32'h24; tcdm_wen = 1; tcdm_id = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("bp_gnt_c%0d", c), tcdm_gnt, (c < 2));
      if (tcdm_gnt) sb.push_back(model(tcdm_add, 1, 0, 0, 1));
      @(posedge clk_i); #1;
    end
    tcdm_r_ready = 1;
    @(negedge clk_i);
    check("bp_gnt_pop_cycle", tcdm_gnt, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("bp_gnt_after_pop", tcdm_gnt, 1);
    if (tcdm_gnt) sb.push_back(model(tcdm_add, 1, 0, 0, 1));
    @(posedge clk_i); #1;
    idle();
    drain();

    // Out-of-range accesses: one past the top, and just below the base.
    lat_mode = 1;
    issue(BASE + MW * 4, 1, 32'h0, 4'h0, 0);
    issue(BASE - 32'h4, 0, 32'h12345678, 4'hF, 1);
    idle();
    drain();

    // Back-to-back reads of 8 consecutive words, no bubbles.
    t0 = cyc;
    for (int i = 0; i < 8; i++) issue(BASE + 32'h100 + 32'(i * 4), 1, 32'h0, 4'h0, 1'(i));
    check("b2b_cycles", cyc - t0, 8);
    idle();
    drain();

    // Reset with two responses queued: everything flushes at once.
    lat_mode = 0; tcdm_r_ready = 0;
    issue(BASE + 32'h40, 1, 32'h0, 4'h0, 0);
    issue(BASE + 32'h44, 1, 32'h0, 4'h0, 1);
    idle();
    check("pre_rst_valid", tcdm_r_valid, 1);
    #2 rst_i = 1;
    #1;
    check("mid_rst_valid", tcdm_r_valid, 0);
    check("mid_rst_data", tcdm_r_data, 0);
    sb.delete();
    @(posedge clk_i); #3 rst_i = 0;
    @(posedge clk_i); #1;
    tcdm_r_ready = 1; lat_mode = 1;
    issue(BASE + 32'h10, 1, 32'h0, 4'h0, 1);
    idle();
    repeat (3) idle();
    drain();

    // Randomised traffic with random r_ready.
    lat_mode = 0; rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 9) == 0)
          a = BASE + MW * 4 + 32'($urandom_range(0, 4095));
        else
          a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
        issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end
    end
    idle();
    rand_rdy = 0; tcdm_r_ready = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
